aes_inv_key_scheduler: RTL and testbench



---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_sbox.sv | 42 ++++
 rtl/aes_inv_key_scheduler.sv | 175 +++++++++++++++++
 tb/tb_aes_inv_key_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key scheduling blocks.
//
// Contents:
//   AES_NR         number of rounds for AES-128
//   RCON_FWD_INIT  round constant used by the first forward expansion step
//   RCON_INV_INIT  round constant used by the first inverse step (round 10)
//   INV_RCON_POLY  correction term applied when halving rcon in GF(2^8)
//   ks_state_e     key scheduler FSM states
//   xtime()        multiply a GF(2^8) element by {02}
//   rot_word()     AES RotWord: cyclic left rotation of a word by one byte
package aes_pkg;

    localparam int         AES_NR        = 10;
    localparam logic [7:0] RCON_FWD_INIT = 8'h01;
    localparam logic [7:0] RCON_INV_INIT = 8'h36;
    localparam logic [7:0] INV_RCON_POLY = 8'h8D;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ks_state_e;

    // Multiplying by x reduces modulo x^8+x^4+x^3+x+1 when bit 7 falls off.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Four parallel AES forward S-box lookups on one 32-bit word.
//
// Ports:
//   sboxw      in   32  word to substitute, byte 0 at [31:24]
//   new_sboxw  out  32  byte-wise S-box of sboxw
module aes_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    // Table entry 0 sits in the most significant byte so the constant reads
    // in the same order as the published S-box, row by row.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    // Each byte of the word is substituted independently.
    always_comb begin
        new_sboxw = {sbox_byte(sboxw[31:24]), sbox_byte(sboxw[23:16]),
                     sbox_byte(sboxw[15:8]),  sbox_byte(sboxw[7:0])};
    end

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// AES-128 decryption-side key scheduler.
//
// Loads a cipher key, runs the forward expansion up to round key 10 and then
// hands out round keys 10 down to 0, one per request, each produced by running
// the expansion backwards from the key before it. A single aes_sbox instance
// serves both directions.
//
// Parameters:
//   NR    number of rounds, only 10 is accepted
//   WRAP  1: a request at round 0 restores round key 10; 0: it is ignored
//
// Ports:
//   clk        in   1    clock
//   rst_n      in   1    asynchronous active-low reset
//   key_in     in   128  cipher key, word 0 at [127:96]
//   key_load   in   1    capture key_in and start forward expansion
//   busy       out  1    forward expansion in progress
//   key_ready  out  1    round key 10 reached, delivery active
//   rk_req     in   1    step to the previous round key (only while rk_valid)
//   rk_valid   out  1    round_key/round_idx valid
//   round_key  out  128  current round key
//   round_idx  out  4    index of round_key
//   rk_last    out  1    rk_valid and round_idx == 0
module aes_inv_key_scheduler
    import aes_pkg::*;
#(
    parameter int NR   = 10,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         key_ready,
    input  logic         rk_req,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_last
);

    generate
        if (NR != AES_NR) begin : g_nr_check
            $error("aes_inv_key_scheduler: only NR=10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e    state_q, state_d;
    logic [127:0] cur_q, cur_d;
    logic [127:0] saved_q, saved_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   idx_q, idx_d;
    logic         busy_q, ready_q, last_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  i0;
    logic [31:0]  sbox_in, sbox_out;
    logic [127:0] fwd_key, inv_key;

    assign w0 = cur_q[127:96];
    assign w1 = cur_q[95:64];
    assign w2 = cur_q[63:32];
    assign w3 = cur_q[31:0];

    // Undoing the chained XORs recovers words 1..3 of the previous key
    // directly; word 3 of the previous key then feeds the S-box, exactly as
    // the current key's word 3 does when expanding forward.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign sbox_in = rot_word((state_q == EXPAND) ? w3 : p3);

    aes_sbox u_sbox (
        .sboxw     (sbox_in),
        .new_sboxw (sbox_out)
    );

    assign f0 = w0 ^ sbox_out ^ {rcon_q, 24'h0};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign i0 = w0 ^ sbox_out ^ {rcon_q, 24'h0};
    assign inv_key = {i0, p1, p2, p3};

    // Next-state logic. A key load restarts everything from any state and
    // wins over a simultaneous round-key request. The last forward step also
    // snapshots round key 10 so a wrap can restore it in a single cycle, and
    // primes rcon with the round 10 constant for the first inverse step.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        saved_d = saved_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;

        if (key_load) begin
            state_d = EXPAND;
            cur_d   = key_in;
            rcon_d  = RCON_FWD_INIT;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                EXPAND: begin
                    cur_d  = fwd_key;
                    rcon_d = xtime(rcon_q);
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == LAST_IDX - 4'd1) begin
                        saved_d = fwd_key;
                        rcon_d  = RCON_INV_INIT;
                        state_d = READY;
                    end
                end
                READY: begin
                    if (rk_req) begin
                        if (idx_q != 4'd0) begin
                            cur_d  = inv_key;
                            rcon_d = {1'b0, rcon_q[7:1]} ^
                                     (rcon_q[0] ? INV_RCON_POLY : 8'h00);
                            idx_d  = idx_q - 4'd1;
                        end else if (WRAP) begin
                            cur_d  = saved_q;
                            rcon_d = RCON_INV_INIT;
                            idx_d  = LAST_IDX;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers. The flags are computed from the next-state
    // values so that every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            saved_q <= '0;
            rcon_q  <= RCON_FWD_INIT;
            idx_q   <= 4'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            saved_q <= saved_d;
            rcon_q  <= rcon_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d == EXPAND);
            ready_q <= (state_d == READY);
            last_q  <= (state_d == READY) && (idx_d == 4'd0);
        end
    end

    assign busy      = busy_q;
    assign key_ready = ready_q;
    assign rk_valid  = ready_q;
    assign rk_last   = last_q;
    assign round_key = cur_q;
    assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// Self-checking bench for aes_inv_key_scheduler.
//
// Two instances share all inputs: dut wraps at round 0, dut_nowrap holds.
// Stimulus pushes the expected presentation of dut into a queue; a monitor
// pops and compares whenever dut presents a new round key.
module tb_aes_inv_key_scheduler;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic         rk_req;

    logic         busy, key_ready, rk_valid, rk_last;
    logic [127:0] round_key;
    logic [3:0]   round_idx;

    logic         busy_nw, key_ready_nw, rk_valid_nw, rk_last_nw;
    logic [127:0] round_key_nw;
    logic [3:0]   round_idx_nw;

    exp_t         sb_q[$];
    logic [127:0] rk_exp [0:10];
    int           cur_idx;
    int           n_compared;
    int           n_mismatched;
    logic         prev_valid;
    logic         req_seen;

    aes_inv_key_scheduler #(.NR(10), .WRAP(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_load  (key_load),
        .busy      (busy),
        .key_ready (key_ready),
        .rk_req    (rk_req),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_last   (rk_last)
    );

    aes_inv_key_scheduler #(.NR(10), .WRAP(1'b0)) dut_nowrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_load  (key_load),
        .busy      (busy_nw),
        .key_ready (key_ready_nw),
        .rk_req    (rk_req),
        .rk_valid  (rk_valid_nw),
        .round_key (round_key_nw),
        .round_idx (round_idx_nw),
        .rk_last   (rk_last_nw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // GF(2^8) multiply, shift-and-add form.
    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from its algebraic definition: inverse (x^254) then affine map.
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] r, base, e;
        r = 8'h01;
        base = x;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = m_gmul(r, base);
            base = m_gmul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
               {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // Word-array key expansion as in the AES standard; published vectors
    // replace the model entries where they exist.
    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = m_gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        if (key == KEY_A) begin
            rk_exp[10] = A_RK10;
            rk_exp[1]  = A_RK1;
            rk_exp[0]  = KEY_A;
        end
        if (key == KEY_B) rk_exp[10] = B_RK10;
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.idx  = 4'(idx);
        e.key  = rk_exp[idx];
        e.last = (idx == 0);
        sb_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic load, input logic [127:0] key, input logic req);
        key_load = load;
        key_in   = key;
        rk_req   = req;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        rk_req   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_key(input logic [127:0] key, input logic also_req, input string name);
        int n;
        build_model(key);
        cur_idx = 10;
        push_exp(10);
        apply_stimulus(1'b1, key, also_req);
        check_output({name, "_busy"}, {127'd0, busy}, 128'd1);
        n = 0;
        while (!key_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output({name, "_latency"}, 128'(n), 128'd10);
        check_output({name, "_busy_done"}, {127'd0, busy}, 128'd0);
    endtask

    task automatic descend(input int steps);
        for (int s = 0; s < steps; s++) begin
            if (cur_idx == 0) cur_idx = 10;
            else cur_idx--;
            push_exp(cur_idx);
            apply_stimulus(1'b0, '0, 1'b1);
        end
    endtask

    // Remember whether a request was taken at each rising edge.
    always @(posedge clk) begin
        req_seen = rk_req && rk_valid;
    end

    // A new presentation is either rk_valid rising or an accepted request.
    always @(negedge clk) begin
        exp_t e;
        if (rk_valid && (!prev_valid || req_seen)) begin
            if (sb_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL sb_unexpected: got idx %0d key %h, expected no presentation",
                         round_idx, round_key);
            end else begin
                e = sb_q.pop_front();
                check_output("sb_idx",  {124'd0, round_idx}, {124'd0, e.idx});
                check_output("sb_key",  round_key, e.key);
                check_output("sb_last", {127'd0, rk_last}, {127'd0, e.last});
            end
        end
        prev_valid = rk_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        prev_valid   = 1'b0;
        req_seen     = 1'b0;
        cur_idx      = 0;
        rst_n        = 1'b0;
        key_in       = '0;
        key_load     = 1'b0;
        rk_req       = 1'b0;

        #12;
        check_output("rst_busy",      {127'd0, busy},      128'd0);
        check_output("rst_key_ready", {127'd0, key_ready}, 128'd0);
        check_output("rst_rk_valid",  {127'd0, rk_valid},  128'd0);
        check_output("rst_rk_last",   {127'd0, rk_last},   128'd0);
        check_output("rst_round_key", round_key,           128'd0);
        check_output("rst_round_idx", {124'd0, round_idx}, 128'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(1'b0, '0, 1'b1);
        check_output("idle_req_idx",   {124'd0, round_idx}, 128'd0);
        check_output("idle_req_valid", {127'd0, rk_valid},  128'd0);

        $display("[TB] key A: load and full descent");
        load_key(KEY_A, 1'b0, "load_a");
        descend(10);

        $display("[TB] wrap at round 0");
        descend(1);
        check_output("nowrap_idx",  {124'd0, round_idx_nw}, 128'd0);
        check_output("nowrap_key",  round_key_nw,           KEY_A);
        check_output("nowrap_last", {127'd0, rk_last_nw},   128'd1);
        descend(10);

        $display("[TB] key B: load and full descent");
        load_key(KEY_B, 1'b0, "load_b");
        descend(10);

        $display("[TB] reload during expansion and during delivery");
        apply_stimulus(1'b1, KEY_A, 1'b0);
        idle_cycles(4);
        check_output("mid_expand_busy", {127'd0, busy}, 128'd1);
        load_key(KEY_B, 1'b0, "reload_mid");
        descend(3);
        load_key(KEY_A, 1'b1, "reload_with_req");

        $display("[TB] reset during delivery");
        descend(6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_busy",      {127'd0, busy},      128'd0);
        check_output("arst_key_ready", {127'd0, key_ready}, 128'd0);
        check_output("arst_rk_valid",  {127'd0, rk_valid},  128'd0);
        check_output("arst_rk_last",   {127'd0, rk_last},   128'd0);
        check_output("arst_round_key", round_key,           128'd0);
        check_output("arst_round_idx", {124'd0, round_idx}, 128'd0);
        check_output("arst_nw_key",    round_key_nw,        128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("post_rst_req_idx",   {124'd0, round_idx}, 128'd0);
        check_output("post_rst_req_valid", {127'd0, rk_valid},  128'd0);
        check_output("post_rst_req_key",   round_key,           128'd0);
        load_key(KEY_B, 1'b0, "load_after_rst");

        idle_cycles(3);
        check_output("sb_drain", 128'(sb_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
